// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shared shift/add datapath, one bit per cycle,
// valid/ready on both sides, with divide-by-zero and signed-overflow resolved on accept.
module rv_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      flags
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN:0]   hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [3:0]      flags_q, flags_d;

  logic            is_div, sign_a, sign_b, dz_case, ovf_case;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    is_div      = op[2];
    sign_a      = A[XLEN-1] & (is_div ? ~op[0] : (op == 3'b001 || op == 3'b010));
    sign_b      = B[XLEN-1] & (is_div ? ~op[0] : (op == 3'b001));
    mag_a       = sign_a ? -A : A;
    mag_b       = sign_b ? -B : B;
    dz_case     = is_div && (B == '0);
    ovf_case    = is_div && !op[0] && (A == INT_MIN) && (B == {XLEN{1'b1}});
    if (dz_case) special_res = op[1] ? A : {XLEN{1'b1}};
    else         special_res = op[1] ? {XLEN{1'b0}} : A;
  end

  // Multiply: hi accumulates the multiplicand, {hi,lo} shifts right as multiplier bits retire.
  // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  logic [XLEN:0]   sum, shifted, trial, step_hi;
  logic [XLEN-1:0] step_lo;

  always_comb begin
    sum     = hi_q + {1'b0, (lo_q[0] ? opnd_q : {XLEN{1'b0}})};
    shifted = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    trial   = shifted - {1'b0, opnd_q};
    if (op_q[2]) begin
      step_hi = trial[XLEN] ? shifted : trial;
      step_lo = {lo_q[XLEN-2:0], ~trial[XLEN]};
    end else begin
      step_hi = {1'b0, sum[XLEN:1]};
      step_lo = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod_mag, prod;
  logic [XLEN-1:0]   quo, rem, final_res;

  always_comb begin
    prod_mag = {step_hi[XLEN-1:0], step_lo};
    prod     = neg_q ? -prod_mag : prod_mag;
    quo      = neg_q ? -step_lo : step_lo;
    rem      = neg_q ? -step_hi[XLEN-1:0] : step_hi[XLEN-1:0];
    if (op_q[2])            final_res = op_q[1] ? rem : quo;
    else if (op_q == 3'b000) final_res = prod[XLEN-1:0];
    else                    final_res = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !kill) begin
          op_d  = op;
          // REM only ever returns the remainder, so one recorded sign suffices per op.
          neg_d = (is_div && op[1]) ? sign_a : (sign_a ^ sign_b);
          if (dz_case || ovf_case) begin
            state_d  = DONE;
            result_d = special_res;
            flags_d  = {ovf_case, dz_case, special_res[XLEN-1], special_res == '0};
          end else begin
            state_d = RUN;
            cnt_d   = CW'(XLEN);
            hi_d    = '0;
            opnd_d  = is_div ? mag_b : mag_a;
            lo_d    = is_div ? mag_a : mag_b;
          end
        end
      end
      RUN: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          hi_d  = step_hi;
          lo_d  = step_lo;
          if (cnt_q == CW'(1)) begin
            state_d  = DONE;
            result_d = final_res;
            flags_d  = {2'b00, final_res[XLEN-1], final_res == '0};
          end
        end
      end
      DONE: begin
        if (kill || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed + random scoreboard bench for rv_muldiv_unit (XLEN=32): expected results come
// from a behavioural 64-bit reference model and are popped when out_valid rises.
module tb_rv_muldiv_unit;
  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          tests_run;
  int          tests_failed;
  logic [31:0] last_res;

  rv_muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (a_in),
    .B         (b_in),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t              e;
    logic signed [63:0] x, y;
    logic [63:0]        p;
    logic [31:0]        r;
    logic               ovf, dz, big;
    ovf = 1'b0; dz = 1'b0; r = '0; p = '0;
    x = {{32{a[31]}}, a};
    y = {{32{b[31]}}, b};
    big = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'd1: begin p = x * y; r = p[63:32]; end
      3'd2: begin y = {32'b0, b}; p = x * y; r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0)   begin r = 32'hFFFF_FFFF; dz = 1'b1; end
        else if (big) begin r = a; ovf = 1'b1; end
        else          r = $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
        else        r = a / b;
      end
      3'd6: begin
        if (b == 0)   begin r = a; dz = 1'b1; end
        else if (big) begin r = 32'd0; ovf = 1'b1; end
        else          r = $signed(a) % $signed(b);
      end
      default: begin
        if (b == 0) begin r = a; dz = 1'b1; end
        else        r = a % b;
      end
    endcase
    e.res = r;
    e.flg = {ovf, dz, r[31], r == 32'd0};
    e.lat = (ovf || dz) ? 0 : 32;
    return e;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int k);
    exp_t e;
    checkValue({tag, " scoreboard"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checkValue({tag, " out_valid"}, 32'(out_valid), 32'd1);
      checkValue({tag, " result"}, result, e.res);
      checkValue({tag, " flags"}, {28'b0, flags}, {28'b0, e.flg});
      checkValue({tag, " latency"}, k, e.lat);
      last_res = e.res;
    end
  endtask

  task automatic acceptOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    op       = o;
    a_in     = a;
    b_in     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Leaves the bench 1 time unit after the edge on which out_valid first rose.
  task automatic applyStimulus(input string tag, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b);
    exp_t e;
    int   k;
    logic busy_ready;
    e = model(o, a, b);
    sb_q.push_back(e);
    acceptOp(o, a, b);
    k = 0;
    busy_ready = 1'b0;
    while (!out_valid && k < 100) begin
      if (in_ready) busy_ready = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    checkOutput(tag, k);
    if (e.lat != 0) checkValue({tag, " in_ready while busy"}, 32'(busy_ready), 32'd0);
  endtask

  task automatic releaseOutput(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkValue({tag, " in_ready after done"}, 32'(in_ready), 32'd1);
    checkValue({tag, " out_valid after done"}, 32'(out_valid), 32'd0);
    checkValue({tag, " result held"}, result, last_res);
  endtask

  task automatic expectQuiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checkValue({tag, " out_valid never rose"}, 32'(seen), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    tests_run = 0; tests_failed = 0; last_res = '0;
    reset = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
    op = '0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset in_ready", 32'(in_ready), 32'd1);
    checkValue("reset out_valid", 32'(out_valid), 32'd0);
    checkValue("reset result", result, 32'd0);
    checkValue("reset flags", {28'b0, flags}, 32'd0);
    reset = 1'b0;

    applyStimulus("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    releaseOutput("MUL 7*-3");
    applyStimulus("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    releaseOutput("MULH");
    applyStimulus("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    releaseOutput("MULHU");
    applyStimulus("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    releaseOutput("MULHSU");
    applyStimulus("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    releaseOutput("DIV");
    applyStimulus("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    releaseOutput("REM");
    applyStimulus("DIVU 100/7", 3'd5, 32'd100, 32'd7);
    releaseOutput("DIVU");
    applyStimulus("REMU 100/7", 3'd7, 32'd100, 32'd7);
    releaseOutput("REMU");

    applyStimulus("DIVU 100/0", 3'd5, 32'd100, 32'd0);
    releaseOutput("DIVU dz");
    applyStimulus("REMU 100/0", 3'd7, 32'd100, 32'd0);
    releaseOutput("REMU dz");
    applyStimulus("DIV -5/0", 3'd4, 32'hFFFF_FFFB, 32'd0);
    releaseOutput("DIV dz");
    applyStimulus("REM -5/0", 3'd6, 32'hFFFF_FFFB, 32'd0);
    releaseOutput("REM dz");
    applyStimulus("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    releaseOutput("DIV ovf");
    applyStimulus("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    releaseOutput("REM ovf");

    // Backpressure: consumer stalls for five cycles in DONE.
    out_ready = 1'b0;
    e = model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    applyStimulus("MULHU backpressure", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkValue("stall out_valid", 32'(out_valid), 32'd1);
      checkValue("stall in_ready", 32'(in_ready), 32'd0);
      checkValue("stall result", result, e.res);
      checkValue("stall flags", {28'b0, flags}, {28'b0, e.flg});
    end
    releaseOutput("backpressure");

    // Kill during RUN cycle 10: no result, previous result kept.
    acceptOp(3'd0, 32'd12345, 32'd678);
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checkValue("kill in_ready", 32'(in_ready), 32'd1);
    checkValue("kill out_valid", 32'(out_valid), 32'd0);
    checkValue("kill result kept", result, last_res);
    expectQuiet("after kill", 40);

    // Reset during RUN cycle 20.
    acceptOp(3'd5, 32'd1000, 32'd3);
    repeat (19) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkValue("midreset in_ready", 32'(in_ready), 32'd1);
    checkValue("midreset out_valid", 32'(out_valid), 32'd0);
    checkValue("midreset result", result, 32'd0);
    checkValue("midreset flags", {28'b0, flags}, 32'd0);
    applyStimulus("DIV 9/3", 3'd4, 32'd9, 32'd3);
    releaseOutput("DIV 9/3");

    // Kill in IDLE overrides in_valid.
    in_valid = 1'b1; kill = 1'b1; op = 3'd0; a_in = 32'd5; b_in = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    checkValue("idle kill no accept", 32'(in_ready), 32'd1);
    expectQuiet("idle kill", 40);

    for (int i = 0; i < 12; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      applyStimulus($sformatf("random %0d op%0d", i, r_op), r_op, r_a, r_b);
      releaseOutput("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/rv_muldiv_unit.md
# rv_muldiv_unit

Iterative, parametrised RV32M-style multiply/divide unit for the RISCV32I datapath, sitting beside the single-cycle ALU in the execute stage. It accepts one operation at a time over a valid/ready handshake. It computes all eight M-extension operations with a shared shift/add datapath over XLEN cycles and returns the result with a 4-bit flag vector. The flag vector uses the same {v, c, n, z} bit layout as the ALU, so the existing flag consumers reuse it. Divide-by-zero and signed-overflow cases resolve in one cycle, per the RISC-V spec.

## Interface
- XLEN, 32, operand/result width; legal values are even numbers ≥ 4.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request (IDLE only).
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- A  in  XLEN  rs1 operand (dividend / multiplicand).
- B  in  XLEN  rs2 operand (divisor / multiplier).
- kill  in  1  abort the in-flight operation (pipeline flush).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  operation result.
- flags  out  4  {ovf, dz, n, z}:
  - ovf: signed DIV/REM overflow.
  - dz: divide by zero.
  - n: result[XLEN-1].
  - z: result == 0.

## Operation
- **FSM states:** IDLE, RUN, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- **IDLE:**
  - in_valid=1 → latch op and operand magnitudes, load the iteration counter with XLEN, go to RUN.
  - Special case (any divide op, B==0) → go directly to DONE:
    - DIV/DIVU: result all-ones.
    - REM/REMU: result = A.
    - dz=1.
  - Special case (DIV/REM, A == 1<<(XLEN-1), B all-ones) → go directly to DONE:
    - DIV: result = A.
    - REM: result = 0.
    - ovf=1.
- **Sign handling:**
  - Signed operands are converted to magnitudes on accept:
    - MULH: A and B are signed.
    - MULHSU: A is signed, B is unsigned.
    - DIV/REM: A and B are signed.
  - Result sign is recorded on accept:
    - Multiply: sign = sA ^ sB.
    - Quotient: sign = sA ^ sB.
    - Remainder: sign = sA (remainder takes the dividend's sign).
- **Multiply:**
  - Shift-add, one multiplier bit per RUN cycle, into a 2·XLEN accumulator.
  - The final product is negated in 2·XLEN width when the recorded sign is set.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- **Divide:**
  - Restoring division, one quotient bit per RUN cycle.
  - The remainder register is XLEN+1 bits wide to hold the trial subtraction.
  - Quotient and remainder are negated per the recorded signs.
- **RUN:** counter decrements each cycle. On the cycle where the counter reaches 1, the final value is written to result/flags and the FSM goes to DONE.
- **DONE:**
  - result and flags are held stable.
  - out_ready=1 → IDLE on the next edge.
  - A new request is not accepted in the same cycle (in_ready=0 in DONE).
- **Flag rules:**
  - n and z are computed from the final result.
  - ovf and dz are 0 for all multiply ops.
- **kill:**
  - In RUN or DONE → IDLE on the next edge; out_valid drops and no result is delivered.
  - In IDLE → overrides in_valid; no accept takes place.
- **reset:** has priority over kill and over the handshake.

## Timing
- **Reset values:** state=IDLE, in_ready=1, out_valid=0, result=0, flags=4'b0000, counter=0.
- **Normal latency:** accepted at edge E0 → out_valid=1 after edge E(XLEN). That is XLEN cycles after acceptance; 32 cycles for XLEN=32.
- **Special-case latency:** out_valid=1 after edge E0 (1 cycle).
- **Back-to-back throughput:** one op per XLEN+2 cycles, because IDLE must be revisited between ops.
- **Held outputs:** result and flags keep their last value after handshake completion, until the next result write.
- **Mid-operation reset or kill:** no partial result is written. result keeps its previous value on kill and is 0 on reset.

## Test plan
- **Handshake timing:** accept MUL A=7, B=0xFFFFFFFD at E0 → out_valid first high after E32, result=0xFFFFFFEB, flags=0b0010. in_ready is low throughout E1–E33.
- **High-half multiplies:**
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- **Signed division:**
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF (n=1).
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- **Special cases:**
  - DIVU 100/0 → 0xFFFFFFFF, flags=0b0110, 1-cycle latency.
  - REMU 100/0 → 100.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000, flags=0b1010.
  - REM 0x80000000/0xFFFFFFFF → 0, flags=0b1001.
- **Backpressure:** hold out_ready=0 for 5 cycles in DONE → result and flags unchanged, out_valid stays 1. Then out_ready=1 → IDLE next edge, in_ready=1.
- **Abort:** assert kill at RUN cycle 10 → IDLE next edge, out_valid never rises. Assert reset at RUN cycle 20 → all outputs at reset values next edge. A following DIV 9/3 completes correctly with result=3.
